// File: rtl/match_index_serializer.sv
// Serialises a captured match mask into one valid/ready beat per set bit,
// lowest index first, carrying the index and the matching element value.
module match_index_serializer #(
    parameter  int WIDTH = 4,
    parameter  int SIZE  = 8,
    localparam int IDX_W = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIZE-1:0]       in_mask,
    input  logic [SIZE*WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      out_index,
    output logic [WIDTH-1:0]      out_value,
    output logic                  out_last,
    output logic [IDX_W:0]        match_count,
    output logic                  empty_pulse
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t                     state_q, state_d;
    logic [SIZE-1:0]            rem_mask_q, rem_mask_d;
    logic [SIZE-1:0][WIDTH-1:0] data_q, data_d;
    logic [IDX_W:0]             match_count_q, match_count_d;
    logic                       empty_pulse_q, empty_pulse_d;
    logic                       out_valid_q, out_valid_d;
    logic [IDX_W-1:0]           out_index_q, out_index_d;
    logic [WIDTH-1:0]           out_value_q, out_value_d;
    logic                       out_last_q, out_last_d;
    logic                       accept;

    function automatic logic [IDX_W:0] popcount(input logic [SIZE-1:0] m);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < SIZE; i++) begin
            c = c + {{IDX_W{1'b0}}, m[i]};
        end
        return c;
    endfunction

    // Scanning downward leaves the lowest set position as the final result.
    function automatic logic [IDX_W-1:0] lowest_index(input logic [SIZE-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic is_single(input logic [SIZE-1:0] m);
        return (m != '0) && ((m & (m - SIZE'(1))) == '0);
    endfunction

    assign in_ready = (state_q == IDLE) && rst_n;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d       = state_q;
        rem_mask_d    = rem_mask_q;
        data_d        = data_q;
        match_count_d = match_count_q;
        empty_pulse_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    rem_mask_d    = in_mask;
                    data_d        = in_data;
                    match_count_d = popcount(in_mask);
                    if (in_mask != '0) begin
                        state_d = EMIT;
                    end else begin
                        empty_pulse_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_valid_q && out_ready) begin
                    rem_mask_d = rem_mask_q & (rem_mask_q - SIZE'(1));
                    if (out_last_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Beat outputs are precomputed from the next mask so they leave a flop.
        out_valid_d = (state_d == EMIT);
        out_index_d = lowest_index(rem_mask_d);
        out_last_d  = (state_d == EMIT) && is_single(rem_mask_d);
        out_value_d = (rem_mask_d != '0) ? data_d[out_index_d] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rem_mask_q    <= '0;
            data_q        <= '0;
            match_count_q <= '0;
            empty_pulse_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_index_q   <= '0;
            out_value_q   <= '0;
            out_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rem_mask_q    <= rem_mask_d;
            data_q        <= data_d;
            match_count_q <= match_count_d;
            empty_pulse_q <= empty_pulse_d;
            out_valid_q   <= out_valid_d;
            out_index_q   <= out_index_d;
            out_value_q   <= out_value_d;
            out_last_q    <= out_last_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_index   = out_index_q;
    assign out_value   = out_value_q;
    assign out_last    = out_last_q;
    assign match_count = match_count_q;
    assign empty_pulse = empty_pulse_q;

endmodule

// File: tb/tb_match_index_serializer.sv
// Randomised and directed checks of match_index_serializer against a
// queue-based model of the beats each accepted vector should produce.
module tb_match_index_serializer;

    localparam int WIDTH = 4;
    localparam int SIZE  = 8;
    localparam int IDX_W = 3;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [SIZE-1:0]       in_mask;
    logic [SIZE*WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [IDX_W-1:0]      out_index;
    logic [WIDTH-1:0]      out_value;
    logic                  out_last;
    logic [IDX_W:0]        match_count;
    logic                  empty_pulse;

    match_index_serializer #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mask    (in_mask),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .out_value  (out_value),
        .out_last   (out_last),
        .match_count(match_count),
        .empty_pulse(empty_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int idx;
        int val;
        bit last;
    } beat_t;

    beat_t pending[$];
    int    exp_count;
    bit    exp_empty;
    bit    exp_zero_outs;
    int    total_checks;
    int    bad_checks;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, advances the model across the edge, then checks.
    task automatic applyStimulus(input logic r, input logic v, input logic [SIZE-1:0] m,
                                 input logic [SIZE*WIDTH-1:0] d, input logic rdy);
        int    ones;
        int    seen;
        beat_t b;
        rst_n     = r;
        in_valid  = v;
        in_mask   = m;
        in_data   = d;
        out_ready = rdy;

        if (!r) begin
            pending.delete();
            exp_count     = 0;
            exp_empty     = 0;
            exp_zero_outs = 1;
        end else begin
            exp_empty = 0;
            if (pending.size() != 0) begin
                if (rdy) void'(pending.pop_front());
            end else if (v) begin
                ones      = $countones(m);
                exp_count = ones;
                if (ones == 0) begin
                    exp_empty = 1;
                end else begin
                    exp_zero_outs = 0;
                    seen = 0;
                    for (int i = 0; i < SIZE; i++) begin
                        if (m[i]) begin
                            seen++;
                            b.idx  = i;
                            b.val  = int'(d[WIDTH*i +: WIDTH]);
                            b.last = (seen == ones);
                            pending.push_back(b);
                        end
                    end
                end
            end
        end

        @(posedge clk);
        @(negedge clk);

        checkOutput("in_ready", 32'(in_ready), 32'(r && pending.size() == 0));
        checkOutput("out_valid", 32'(out_valid), 32'(pending.size() != 0));
        if (pending.size() != 0) begin
            checkOutput("out_index", 32'(out_index), 32'(pending[0].idx));
            checkOutput("out_value", 32'(out_value), 32'(pending[0].val));
            checkOutput("out_last", 32'(out_last), 32'(pending[0].last));
        end else if (exp_zero_outs) begin
            checkOutput("idle_index", 32'(out_index), 32'd0);
            checkOutput("idle_value", 32'(out_value), 32'd0);
            checkOutput("idle_last", 32'(out_last), 32'd0);
        end
        checkOutput("match_count", 32'(match_count), 32'(exp_count));
        checkOutput("empty_pulse", 32'(empty_pulse), 32'(exp_empty));
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        logic [SIZE-1:0]       rm;
        logic [SIZE*WIDTH-1:0] rd;
        int                    pick;
        total_checks  = 0;
        bad_checks    = 0;
        exp_count     = 0;
        exp_empty     = 0;
        exp_zero_outs = 1;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_mask       = '0;
        in_data       = '0;
        out_ready     = 1'b0;

        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 32'hFFFF_FFFF, 1'b1);
        idleCycles(1);

        // Basic three-beat vector with an always-ready sink.
        applyStimulus(1'b1, 1'b1, 8'h25, 32'h7654_3210, 1'b1);
        checkOutput("t1_first_idx", 32'(out_index), 32'd0);
        idleCycles(3);
        checkOutput("t1_count", 32'(match_count), 32'd3);
        checkOutput("t1_ready", 32'(in_ready), 32'd1);

        // Backpressure while index 2 is presented.
        applyStimulus(1'b1, 1'b1, 8'h25, 32'h7654_3210, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
        checkOutput("t2_held_idx", 32'(out_index), 32'd2);
        idleCycles(2);

        // Empty mask.
        applyStimulus(1'b1, 1'b1, 8'h00, 32'h1234_5678, 1'b1);
        idleCycles(2);

        // Full mask.
        applyStimulus(1'b1, 1'b1, 8'hFF, 32'hFEDC_BA98, 1'b1);
        idleCycles(8);
        checkOutput("t4_count", 32'(match_count), 32'd8);

        // Reset in the middle of emission, then a single-bit vector.
        applyStimulus(1'b1, 1'b1, 8'hC1, 32'hABCD_EF01, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h02, 32'h0000_00A0, 1'b0);
        checkOutput("t5_idx", 32'(out_index), 32'd1);
        checkOutput("t5_last", 32'(out_last), 32'd1);
        idleCycles(2);

        // Second vector held on the input throughout the first one's emission.
        applyStimulus(1'b1, 1'b1, 8'h0A, 32'h1111_2222, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 8'h11, 32'h3333_4444, 1'b1);
        idleCycles(3);

        for (int n = 0; n < 3000; n++) begin
            pick = int'($urandom_range(0, 7));
            case (pick)
                0:       rm = 8'h00;
                1:       rm = 8'hFF;
                2:       rm = 8'h01 << $urandom_range(0, 7);
                default: rm = SIZE'($urandom);
            endcase
            rd = $urandom;
            applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 2) != 0, rm, rd,
                          $urandom_range(0, 9) < 7);
        end

        idleCycles(12);
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
